// File: rtl/nibble_arb_pkg.sv
// Shared definitions for the nibble adder arbiter.
//   WIDTH_DEF : default operand width
//   SRC_A/B   : encoding of the result source tag
//   res_t     : result bundle {carry, sum, src} at the default width
package nibble_arb_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef struct packed {
        logic                 carry;
        logic [WIDTH_DEF-1:0] sum;
        logic                 src;
    } res_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit 0 = A, bit 1 = B
//   advance    : the current grant was taken; remember it as last grant
//   gnt[1:0]   : one-hot grant, or zero when nothing is requested
module rr_arb2
    import nibble_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Under contention the side that did not win last time goes next.
            2'b11:   gnt = (r_last_grant == SRC_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= SRC_B;
        end else if (advance) begin
            r_last_grant <= gnt[1] ? SRC_B : SRC_A;
        end
    end

endmodule

// File: rtl/nibble_adder_arbiter.sv
// One registered adder shared by two valid/ready requesters (A, B).
// A round-robin arbiter picks the requester; the sum, carry and source tag
// land in a one-deep output register with valid/ready backpressure.
//   a_*/b_*     : requester handshakes and operand pairs
//   res_valid/res_ready : result handshake
//   res_sum/res_carry/res_src : registered result and its source (0=A, 1=B)
//   ops_cnt     : wrapping count of completed result handshakes
module nibble_adder_arbiter
    import nibble_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_op0,
    input  logic [WIDTH-1:0] a_op1,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_op0,
    input  logic [WIDTH-1:0] b_op1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_src,
    output logic [CNT_W-1:0] ops_cnt
);

    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_sum;
    logic             r_res_carry;
    logic             r_res_src;
    logic [CNT_W-1:0] r_ops_cnt;

    logic [1:0]       w_gnt;
    logic             w_can_accept;
    logic             w_accept;
    logic             w_drain;
    logic             w_sel_b;
    logic [WIDTH-1:0] w_op0;
    logic [WIDTH-1:0] w_op1;
    logic [WIDTH:0]   w_sum;

    // The output register can take a new result when empty or being drained
    // in this same cycle.
    assign w_can_accept = !r_res_valid || res_ready;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({b_valid, a_valid}),
        .advance (w_accept),
        .gnt     (w_gnt)
    );

    // Ready is held low while reset is asserted so no handshake is signalled.
    assign a_ready  = rst_n && w_can_accept && w_gnt[0];
    assign b_ready  = rst_n && w_can_accept && w_gnt[1];
    // A grant only exists for a valid requester, so ready implies accept.
    assign w_accept = a_ready || b_ready;
    assign w_drain  = r_res_valid && res_ready;

    assign w_sel_b = w_gnt[1];
    assign w_op0   = w_sel_b ? b_op0 : a_op0;
    assign w_op1   = w_sel_b ? b_op1 : a_op1;
    assign w_sum   = {1'b0, w_op0} + {1'b0, w_op1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_carry <= 1'b0;
            r_res_src   <= SRC_A;
        end else if (w_accept) begin
            {r_res_carry, r_res_sum} <= w_sum;
            r_res_src                <= w_sel_b ? SRC_B : SRC_A;
            r_res_valid              <= 1'b1;
        end else if (w_drain) begin
            r_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops_cnt <= '0;
        end else if (w_drain) begin
            r_ops_cnt <= r_ops_cnt + 1'b1;
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_carry = r_res_carry;
    assign res_src   = r_res_src;
    assign ops_cnt   = r_ops_cnt;

endmodule

// File: tb/tb_nibble_adder_arbiter.sv
module tb_nibble_adder_arbiter;
    import nibble_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       a_valid, a_ready;
    logic [3:0] a_op0, a_op1;
    logic       b_valid, b_ready;
    logic [3:0] b_op0, b_op1;
    logic       res_valid, res_ready;
    logic [3:0] res_sum;
    logic       res_carry, res_src;
    logic [7:0] ops_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    res_t exp_res;

    nibble_adder_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_op0     (a_op0),
        .a_op1     (a_op1),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_op0     (b_op0),
        .b_op1     (b_op1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_src   (res_src),
        .ops_cnt   (ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, ".valid"}, 32'(res_valid), 32'd1);
        chk({tag, ".sum"},   32'(res_sum),   32'(e.sum));
        chk({tag, ".carry"}, 32'(res_carry), 32'(e.carry));
        chk({tag, ".src"},   32'(res_src),   32'(e.src));
    endtask

    initial begin
        // Reset with both requesters valid
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b0;
        a_op0 = 4'd7; a_op1 = 4'd5; b_op0 = 4'hF; b_op1 = 4'h3;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst.res_valid", 32'(res_valid), 32'd0);
            chk("rst.ops_cnt",   32'(ops_cnt),   32'd0);
            chk("rst.a_ready",   32'(a_ready),   32'd0);
            chk("rst.b_ready",   32'(b_ready),   32'd0);
            tick();
        end
        chk("rst.res_sum", 32'(res_sum), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.a_first", 32'(a_ready), 32'd1);
        chk("rel.b_wait",  32'(b_ready), 32'd0);

        // Single A request: 7 + 5 = 0xC
        b_valid = 1'b0; res_ready = 1'b1;
        #1;
        chk("singleA.a_ready", 32'(a_ready), 32'd1);
        tick();
        exp_res = '{carry: 1'b0, sum: 4'hC, src: SRC_A};
        chk_res("singleA", exp_res);
        chk("singleA.cnt", 32'(ops_cnt), 32'd0);

        // Carry out from B: 0xF + 0x3 = 0x12
        a_valid = 1'b0; b_valid = 1'b1;
        #1;
        chk("carryB.b_ready", 32'(b_ready), 32'd1);
        tick();
        exp_res = '{carry: 1'b1, sum: 4'h2, src: SRC_B};
        chk_res("carryB", exp_res);
        chk("carryB.cnt", 32'(ops_cnt), 32'd1);
        b_valid = 1'b0;
        tick();
        chk("idle.res_valid", 32'(res_valid), 32'd0);
        chk("idle.cnt", 32'(ops_cnt), 32'd2);
        exp_cnt = 2;

        // Contention: A = 1+2 = 3, B = 9+9 = 0x12; last grant was B so A first
        a_op0 = 4'd1; a_op1 = 4'd2; b_op0 = 4'd9; b_op1 = 4'd9;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i % 2 == 0) exp_res = '{carry: 1'b0, sum: 4'h3, src: SRC_A};
            else            exp_res = '{carry: 1'b1, sum: 4'h2, src: SRC_B};
            chk_res($sformatf("cont%0d", i), exp_res);
            if (i > 0) exp_cnt++;
            chk($sformatf("cont%0d.cnt", i), 32'(ops_cnt), 32'(exp_cnt));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        exp_cnt++;
        chk("cont.total", 32'(ops_cnt - 8'd2), 32'd6);
        chk("cont.empty", 32'(res_valid), 32'd0);

        // Backpressure: result A pending, consumer stalls for 3 cycles
        res_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        tick();
        exp_res = '{carry: 1'b0, sum: 4'h3, src: SRC_A};
        chk_res("bp.load", exp_res);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d.a_ready", i), 32'(a_ready), 32'd0);
            chk($sformatf("bp%0d.b_ready", i), 32'(b_ready), 32'd0);
            tick();
            chk_res($sformatf("bp%0d.hold", i), exp_res);
            chk($sformatf("bp%0d.cnt", i), 32'(ops_cnt), 32'(exp_cnt));
        end
        // Pass-through: drain and accept B in the same cycle
        res_ready = 1'b1;
        #1;
        chk("pt.b_ready", 32'(b_ready), 32'd1);
        chk("pt.a_ready", 32'(a_ready), 32'd0);
        tick();
        exp_cnt++;
        exp_res = '{carry: 1'b1, sum: 4'h2, src: SRC_B};
        chk_res("pt", exp_res);
        chk("pt.cnt", 32'(ops_cnt), 32'(exp_cnt));
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        exp_cnt++;
        chk("pt.empty", 32'(res_valid), 32'd0);
        chk("pt.cnt2", 32'(ops_cnt), 32'(exp_cnt));

        // Counter wrap: keep A streaming until the count rolls over
        a_valid = 1'b1;
        tick();
        chk("wrap.load", 32'(res_valid), 32'd1);
        for (int i = 0; i < 256; i++) begin
            if (exp_cnt == 255) begin
                chk("wrap.pre", 32'(ops_cnt), 32'd255);
            end
            tick();
            exp_cnt = (exp_cnt + 1) % 256;
        end
        chk("wrap.cnt", 32'(ops_cnt), 32'(exp_cnt));
        chk("wrap.full_cycle", 32'(ops_cnt), 32'd10);
        chk("wrap.valid", 32'(res_valid), 32'd1);

        // Asynchronous reset with a result pending
        rst_n = 1'b0;
        #1;
        chk("areset.res_valid", 32'(res_valid), 32'd0);
        chk("areset.cnt", 32'(ops_cnt), 32'd0);
        chk("areset.a_ready", 32'(a_ready), 32'd0);
        tick();
        rst_n = 1'b1; b_valid = 1'b1;
        #1;
        chk("areset.a_prio", 32'(a_ready), 32'd1);
        chk("areset.b_wait", 32'(b_ready), 32'd0);
        tick();
        exp_res = '{carry: 1'b0, sum: 4'h3, src: SRC_A};
        chk_res("areset.first", exp_res);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
